// File: rtl/caches_pkg.sv
// Shared types for the cache memory-side blocks.
//   ramstate_t  : RAM controller status (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t : arbiter FSM states (IDLE, DGRANT, IGRANT)
//   word_t      : one memory word
package caches_pkg;

   localparam int unsigned WordW = 32;

   typedef logic [WordW-1:0] word_t;

   typedef enum logic [1:0] {
      RamFree   = 2'd0,
      RamBusy   = 2'd1,
      RamAccess = 2'd2,
      RamError  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StDGrant = 2'd1,
      StIGrant = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_fair_counter.sv
// Saturating counter used to track consecutive dcache grants taken while the
// icache is waiting.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   inc_i        : count up by one (ignored once saturated)
//   clr_i        : clear to zero, wins over inc_i
//   sat_o        : counter has reached Max
module arb_fair_counter #(
   parameter int unsigned Max  = 4,
   parameter int unsigned CntW = $clog2(Max + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign sat_o = (cnt_q == CntW'(Max));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !sat_o) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing the single RAM port between the icache and the dcache.
// A dcache grant is held for a whole BLK_WORDS block; an icache grant lasts
// one beat. A fairness counter forces an icache grant after STARVE_MAX
// consecutive dcache grants taken while iREN was pending.
//   CLK, RST                 : clock, asynchronous active-high reset
//   iREN, iaddr              : icache read request / word address
//   iwait, iload             : icache handshake (low for the completing beat) / data
//   dREN, dWEN, daddr, dstore: dcache request, address, write data
//   dwait, dload             : dcache handshake / data
//   ramREN, ramWEN, ramaddr, ramstore : RAM request side
//   ramload, ramstate        : RAM read data and status
//   mem_err                  : sticky RAM error flag
module cache_mem_arbiter
   import caches_pkg::*;
#(
   parameter int unsigned BLK_WORDS  = 2,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [ADDR_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [ADDR_W-1:0] dstore,
   output logic              dwait,
   output logic [ADDR_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [ADDR_W-1:0] ramstore,
   input  logic [ADDR_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              mem_err
);

   localparam int unsigned BeatW = $clog2(BLK_WORDS) + 1;

   arb_state_t       state_q, state_d;
   logic [BeatW-1:0] beat_q, beat_d;
   logic             mem_err_q, mem_err_d;

   ramstate_t ram_st;
   logic      dreq;
   logic      grant_d, grant_i;
   logic      d_done, i_done;
   logic      err_now;
   logic      starve_inc, starve_clr, starve_sat;

   assign ram_st = ramstate_t'(ramstate);
   assign dreq   = dREN | dWEN;

   arb_fair_counter #(
      .Max (STARVE_MAX)
   ) u_starve_cnt (
      .clk_i (CLK),
      .rst_i (RST),
      .inc_i (starve_inc),
      .clr_i (starve_clr),
      .sat_o (starve_sat)
   );

   // Next state, arbitration and beat accounting.
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      d_done     = 1'b0;
      i_done     = 1'b0;
      starve_inc = 1'b0;
      starve_clr = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (dreq && !starve_sat) begin
               grant_d = 1'b1;
            end else if (iREN) begin
               grant_i = 1'b1;
            end else if (dreq) begin
               grant_d = 1'b1;
            end
            if (grant_d) begin
               state_d    = StDGrant;
               beat_d     = '0;
               starve_inc = iREN;
            end
            if (grant_i) begin
               state_d = StIGrant;
            end
            starve_clr = grant_i | ~iREN;
         end
         StDGrant: begin
            if (!dreq) begin
               state_d = StIdle;
               beat_d  = '0;
            end else if (ram_st == RamAccess) begin
               d_done = 1'b1;
               if (beat_q + BeatW'(1) == BeatW'(BLK_WORDS)) begin
                  state_d = StIdle;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + BeatW'(1);
               end
            end
         end
         StIGrant: begin
            if (!iREN) begin
               state_d = StIdle;
            end else if (ram_st == RamAccess) begin
               i_done  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ERROR only counts while someone owns the port; it never completes a beat.
   assign err_now   = (state_q != StIdle) && (ram_st == RamError);
   assign mem_err_d = mem_err_q | err_now;

   // Request/response mux; forced to reset values while RST is held.
   always_comb begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      mem_err  = 1'b0;
      if (!RST) begin
         iwait   = ~i_done;
         dwait   = ~d_done;
         iload   = ramload;
         dload   = ramload;
         mem_err = mem_err_d;
         if ((state_q == StDGrant) || grant_d) begin
            ramREN   = dREN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
         end else if ((state_q == StIGrant) || grant_i) begin
            ramREN  = iREN;
            ramaddr = iaddr;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= StIdle;
         beat_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         mem_err_q <= mem_err_d;
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled 3 units later, well away from either edge.
module tb_cache_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN, dWEN;
   logic [31:0] daddr, dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;
   logic        mem_err;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

   always #5 CLK = ~CLK;

   cache_mem_arbiter #(
      .BLK_WORDS  (2),
      .STARVE_MAX (4),
      .ADDR_W     (32)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .mem_err  (mem_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      // Reset held with requests pending: everything must sit at reset values.
      RST = 1'b1; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; dWEN = 1'b0;
      daddr = 32'h100; dstore = 32'h0; ramload = 32'h55; ramstate = ACCESS;
      #1; settle();
      chk("rst_iwait",    {31'd0, iwait},   32'd1);
      chk("rst_dwait",    {31'd0, dwait},   32'd1);
      chk("rst_ramREN",   {31'd0, ramREN},  32'd0);
      chk("rst_ramWEN",   {31'd0, ramWEN},  32'd0);
      chk("rst_ramaddr",  ramaddr,          32'd0);
      chk("rst_ramstore", ramstore,         32'd0);
      chk("rst_iload",    iload,            32'd0);
      chk("rst_dload",    dload,            32'd0);
      chk("rst_mem_err",  {31'd0, mem_err}, 32'd0);
      tick();

      // Single icache read: BUSY, BUSY, ACCESS.
      RST = 1'b0; iREN = 1'b0; dREN = 1'b0; ramstate = FREE; tick();
      iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; settle();
      chk("ird_c0_ramREN",  {31'd0, ramREN}, 32'd1);
      chk("ird_c0_ramaddr", ramaddr,         32'h40);
      chk("ird_c0_iwait",   {31'd0, iwait},  32'd1);
      tick(); settle();
      chk("ird_c1_ramREN",  {31'd0, ramREN}, 32'd1);
      chk("ird_c1_iwait",   {31'd0, iwait},  32'd1);
      tick(); ramstate = ACCESS; ramload = 32'hDEADBEEF; settle();
      chk("ird_c2_iwait",   {31'd0, iwait},  32'd0);
      chk("ird_c2_iload",   iload,           32'hDEADBEEF);
      chk("ird_c2_dwait",   {31'd0, dwait},  32'd1);
      // Back in IDLE: a fresh dcache request is forwarded at once.
      tick(); iREN = 1'b0; ramstate = FREE; dREN = 1'b1; daddr = 32'h200; settle();
      chk("ird_idle_ramaddr", ramaddr,         32'h200);
      chk("ird_idle_ramREN",  {31'd0, ramREN}, 32'd1);
      tick(); dREN = 1'b0; tick(); tick();

      // Dcache 2-beat writeback, icache raised after beat 1.
      dWEN = 1'b1; daddr = 32'h100; dstore = 32'h11; ramstate = ACCESS; settle();
      chk("wb_c0_ramWEN",   {31'd0, ramWEN}, 32'd1);
      chk("wb_c0_ramaddr",  ramaddr,         32'h100);
      chk("wb_c0_ramstore", ramstore,        32'h11);
      tick(); settle();
      chk("wb_b1_dwait",    {31'd0, dwait},  32'd0);
      chk("wb_b1_ramaddr",  ramaddr,         32'h100);
      tick(); daddr = 32'h104; dstore = 32'h22; iREN = 1'b1; iaddr = 32'h40; settle();
      chk("wb_b2_dwait",    {31'd0, dwait},  32'd0);
      chk("wb_b2_ramaddr",  ramaddr,         32'h104);
      chk("wb_b2_ramstore", ramstore,        32'h22);
      chk("wb_b2_iwait",    {31'd0, iwait},  32'd1);
      chk("wb_b2_ramREN",   {31'd0, ramREN}, 32'd0);
      tick(); dWEN = 1'b0; settle();
      chk("wb_rel_ramREN",  {31'd0, ramREN}, 32'd1);
      chk("wb_rel_ramaddr", ramaddr,         32'h40);
      chk("wb_rel_ramWEN",  {31'd0, ramWEN}, 32'd0);
      chk("wb_rel_iwait",   {31'd0, iwait},  32'd1);
      tick(); settle();
      chk("wb_ig_iwait",    {31'd0, iwait},  32'd0);
      tick(); iREN = 1'b0; ramstate = FREE; tick();

      // Simultaneous iREN + dREN with the fairness counter at zero.
      iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h300; settle();
      chk("sim_c0_ramaddr", ramaddr,        32'h300);
      chk("sim_c0_iwait",   {31'd0, iwait}, 32'd1);
      tick(); ramstate = ACCESS; ramload = 32'hA1; settle();
      chk("sim_b1_dwait",   {31'd0, dwait}, 32'd0);
      chk("sim_b1_dload",   dload,          32'hA1);
      chk("sim_b1_iwait",   {31'd0, iwait}, 32'd1);
      tick(); daddr = 32'h304; settle();
      chk("sim_b2_dwait",   {31'd0, dwait}, 32'd0);
      tick(); dREN = 1'b0; ramstate = FREE; settle();
      chk("sim_dead_ramaddr", ramaddr,        32'h80);
      chk("sim_dead_iwait",   {31'd0, iwait}, 32'd1);
      tick(); ramstate = ACCESS; ramload = 32'hB2; settle();
      chk("sim_ig_iwait",   {31'd0, iwait}, 32'd0);
      chk("sim_ig_iload",   iload,          32'hB2);
      tick(); iREN = 1'b0; ramstate = FREE; tick();

      // Starvation: four dcache blocks win, then the icache is forced in.
      iREN = 1'b1; iaddr = 32'hC0; dREN = 1'b1;
      for (int k = 0; k < 4; k++) begin
         daddr = 32'h400 + 32'(k) * 32'h10; ramstate = FREE; settle();
         chk($sformatf("stv_d%0d_ramaddr", k), ramaddr, 32'h400 + 32'(k) * 32'h10);
         tick(); ramstate = ACCESS; settle();
         chk($sformatf("stv_d%0d_dwait", k), {31'd0, dwait}, 32'd0);
         tick(); tick();
      end
      daddr = 32'h440; ramstate = FREE; settle();
      chk("stv_force_ramaddr", ramaddr,         32'hC0);
      chk("stv_force_ramREN",  {31'd0, ramREN}, 32'd1);
      tick(); ramstate = ACCESS; settle();
      chk("stv_ig_iwait",      {31'd0, iwait},  32'd0);
      chk("stv_ig_dwait",      {31'd0, dwait},  32'd1);
      tick(); ramstate = FREE; settle();
      chk("stv_d5_ramaddr",    ramaddr,         32'h440);
      tick(); ramstate = ACCESS; tick(); tick();
      iREN = 1'b0; dREN = 1'b0; ramstate = FREE; tick();

      // RAM ERROR during a dcache beat.
      dREN = 1'b1; daddr = 32'h500; settle();
      chk("err_c0_mem_err", {31'd0, mem_err}, 32'd0);
      tick(); ramstate = ERROR; settle();
      chk("err_e_dwait",    {31'd0, dwait},   32'd1);
      chk("err_e_mem_err",  {31'd0, mem_err}, 32'd1);
      tick(); ramstate = BUSY; settle();
      chk("err_held_mem_err", {31'd0, mem_err}, 32'd1);
      chk("err_held_ramaddr", ramaddr,          32'h500);
      chk("err_held_dwait",   {31'd0, dwait},   32'd1);
      tick(); ramstate = ACCESS; settle();
      chk("err_acc_dwait",   {31'd0, dwait},   32'd0);
      chk("err_acc_mem_err", {31'd0, mem_err}, 32'd1);
      tick(); daddr = 32'h504; tick(); dREN = 1'b0; ramstate = FREE; settle();
      chk("err_idle_mem_err", {31'd0, mem_err}, 32'd1);
      tick();

      // Reset pulsed mid-DGRANT after beat 1.
      dWEN = 1'b1; daddr = 32'h600; dstore = 32'h66; ramstate = ACCESS; tick(); settle();
      chk("mrst_b1_dwait", {31'd0, dwait}, 32'd0);
      tick(); daddr = 32'h604; ramload = 32'h77; RST = 1'b1; settle();
      chk("mrst_ramWEN",   {31'd0, ramWEN},  32'd0);
      chk("mrst_ramaddr",  ramaddr,          32'd0);
      chk("mrst_ramstore", ramstore,         32'd0);
      chk("mrst_dwait",    {31'd0, dwait},   32'd1);
      chk("mrst_dload",    dload,            32'd0);
      chk("mrst_mem_err",  {31'd0, mem_err}, 32'd0);
      tick(); RST = 1'b0; dWEN = 1'b0; iREN = 1'b1; iaddr = 32'h700; ramstate = FREE; settle();
      chk("mrst_i_ramREN",  {31'd0, ramREN}, 32'd1);
      chk("mrst_i_ramaddr", ramaddr,         32'h700);
      tick(); ramstate = ACCESS; ramload = 32'h99; settle();
      chk("mrst_i_iwait",   {31'd0, iwait},  32'd0);
      chk("mrst_i_iload",   iload,           32'h99);
      tick(); iREN = 1'b0; ramstate = FREE; tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
